// File: rtl/zbuf_mem_arbiter.sv
// zbuf_mem_arbiter: shares one Avalon-MM SDRAM master between the z-read,
// depth write-back and color write-out requesters.
// The master command is a zero-latency mux of the granted requester.
// Returning read data is routed through a tag FIFO of requester indices.
// Build option: define ZARB_FIXED_PRIORITY_EN for fixed priority, where the
// lowest index wins. The default build uses round-robin.
module zbuf_mem_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ*AW-1:0]   req_address,
  input  logic [NREQ-1:0]      req_read,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*DW-1:0]   req_writedata,
  input  logic [NREQ*4-1:0]    req_byteenable,
  output logic [NREQ-1:0]      req_waitrequest,
  output logic [DW-1:0]        req_readdata,
  output logic [NREQ-1:0]      req_readdatavalid,
  output logic [AW-1:0]        master_address,
  output logic                 master_read,
  output logic                 master_write,
  output logic [3:0]           master_byteenable,
  output logic [DW-1:0]        master_writedata,
  input  logic                 master_waitrequest,
  input  logic [DW-1:0]        master_readdata,
  input  logic                 master_readdatavalid,
  output logic                 err_orphan_read
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = PW + 1;

  logic          r_lock;
  logic [IW-1:0] r_lock_idx;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_tag [MAX_PEND];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [NREQ-1:0] w_elig;
  logic            w_full, w_empty;
  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_cmd_rd, w_cmd_wr;
  logic            w_accept, w_push, w_pop, w_orphan;
  logic [IW-1:0]   w_head;

  assign w_full  = (r_count == CW'(MAX_PEND));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag[r_rptr];
  // A full FIFO blocks reads even if a pop lands this same cycle.
  assign w_elig  = req_write | (req_read & {NREQ{~w_full}});

  // Grant selection: a held lock wins, otherwise the configured policy applies.
  always_comb begin
    logic [IW-1:0] w_j;
    int            j;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_j       = '0;
    j         = 0;
    if (r_lock) begin
      w_gnt_vld = 1'b1;
      w_gnt_idx = r_lock_idx;
    end else begin
`ifdef ZARB_FIXED_PRIORITY_EN
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (w_elig[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = IW'(i);
        end
      end
`else
      // Scan downward so that the last hit is the first index at or after the pointer.
      for (int k = NREQ - 1; k >= 0; k--) begin
        j = int'(r_rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        w_j = IW'(j);
        if (w_elig[w_j]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_j;
        end
      end
`endif
    end
  end

  // Master mux of the granted command. A write takes precedence over a read.
  always_comb begin
    master_address    = '0;
    master_byteenable = '0;
    master_writedata  = '0;
    w_cmd_rd          = 1'b0;
    w_cmd_wr          = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_vld && w_gnt_idx == IW'(i)) begin
        master_address    = req_address[i*AW +: AW];
        master_byteenable = req_byteenable[i*4 +: 4];
        master_writedata  = req_writedata[i*DW +: DW];
        w_cmd_wr          = req_write[i];
        w_cmd_rd          = req_read[i] & ~req_write[i];
      end
    end
  end

  assign master_read  = w_cmd_rd & ~reset;
  assign master_write = w_cmd_wr & ~reset;
  assign w_accept     = (w_cmd_rd | w_cmd_wr) & ~master_waitrequest & ~reset;
  assign w_push       = w_accept & w_cmd_rd;
  assign w_pop        = master_readdatavalid & ~w_empty & ~reset;
  assign w_orphan     = master_readdatavalid & w_empty & ~reset;
  assign req_readdata = master_readdata;
  assign err_orphan_read = r_err;

  // Per-requester handshake and one-hot routing of returned read data.
  always_comb begin
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept && w_gnt_idx == IW'(i)) req_waitrequest[i] = 1'b0;
      if (w_pop && w_head == IW'(i))       req_readdatavalid[i] = 1'b1;
    end
  end

  // Lock, round-robin pointer, tag FIFO pointers and the sticky orphan flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_gnt_vld && master_waitrequest) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt_idx;
      end else begin
        r_lock     <= 1'b0;
      end
      if (w_accept)
        r_rr_ptr <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_orphan) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset because the count qualifies every entry.
  always_ff @(posedge clock) begin
    if (w_push) r_tag[r_wptr] <= w_gnt_idx;
  end
endmodule

// File: tb/tb_zbuf_mem_arbiter.sv
// Directed bench for zbuf_mem_arbiter with hand-computed expectations.
// The arbitration section follows ZARB_FIXED_PRIORITY_EN when that macro is defined.
module tb_zbuf_mem_arbiter;
  localparam int NREQ = 3, AW = 26, DW = 32, MAX_PEND = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ*AW-1:0]  req_address;
  logic [NREQ-1:0]     req_read, req_write;
  logic [NREQ*DW-1:0]  req_writedata;
  logic [NREQ*4-1:0]   req_byteenable;
  logic [NREQ-1:0]     req_waitrequest;
  logic [DW-1:0]       req_readdata;
  logic [NREQ-1:0]     req_readdatavalid;
  logic [AW-1:0]       master_address;
  logic                master_read, master_write;
  logic [3:0]          master_byteenable;
  logic [DW-1:0]       master_writedata;
  logic                master_waitrequest;
  logic [DW-1:0]       master_readdata;
  logic                master_readdatavalid;
  logic                err_orphan_read;

  int n_cmp = 0, n_bad = 0;

  zbuf_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_PEND(MAX_PEND)) dut (
    .clock(clock), .reset(reset),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .err_orphan_read(err_orphan_read));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    req_read = '0; req_write = '0; req_address = '0;
    req_writedata = '0; req_byteenable = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i] = rd;
    req_write[i] = wr;
    req_address[i*AW +: AW] = a;
    req_writedata[i*DW +: DW] = d;
    req_byteenable[i*4 +: 4] = 4'hF;
  endtask

  logic [NREQ-1:0] exp_wr [4];
  logic [AW-1:0]   exp_ad [4];

  initial begin
    clr();
    reset = 1'b1; master_waitrequest = 1'b0;
    master_readdata = '0; master_readdatavalid = 1'b0;
    // Outputs are forced quiet while reset is held, even with traffic present.
    set_req(2, 1'b0, 1'b1, 26'h100, 32'h1);
    master_readdatavalid = 1'b1;
    #1;
    chk("rst_mwrite", master_write, 0);
    chk("rst_wreq", req_waitrequest, 3'b111);
    chk("rst_rdv", req_readdatavalid, 3'b000);
    tick();
    reset = 1'b0; master_readdatavalid = 1'b0; clr();
    #1;
    chk("rst_err", err_orphan_read, 0);
    chk("idle_wreq", req_waitrequest, 3'b111);
    tick();

    // Single write from requester 2.
    set_req(2, 1'b0, 1'b1, 26'h100, 32'h00AABBCC);
    #1;
    chk("wr_mwrite", master_write, 1);
    chk("wr_mread", master_read, 0);
    chk("wr_addr", master_address, 26'h100);
    chk("wr_data", master_writedata, 32'h00AABBCC);
    chk("wr_be", master_byteenable, 4'hF);
    chk("wr_wreq", req_waitrequest, 3'b011);
    tick(); clr();

    // Lock under stall: requester 1 holds the master through three stalled cycles.
    set_req(1, 1'b0, 1'b1, 26'h200, 32'h1234);
    master_waitrequest = 1'b1;
    #1;
    chk("lk_c1_addr", master_address, 26'h200);
    chk("lk_c1_wreq", req_waitrequest, 3'b111);
    tick();
    set_req(0, 1'b1, 1'b0, 26'h40, 32'h0);
    #1;
    chk("lk_c2_addr", master_address, 26'h200);
    chk("lk_c2_wr", master_write, 1);
    tick(); #1;
    chk("lk_c3_addr", master_address, 26'h200);
    chk("lk_c3_wreq", req_waitrequest, 3'b111);
    tick();
    master_waitrequest = 1'b0;
    #1;
    chk("lk_c4_addr", master_address, 26'h200);
    chk("lk_c4_wreq", req_waitrequest, 3'b101);
    tick();
    req_write[1] = 1'b0;
    #1;
    chk("lk_c5_rd", master_read, 1);
    chk("lk_c5_addr", master_address, 26'h40);
    chk("lk_c5_wreq", req_waitrequest, 3'b110);
    tick(); clr();
    master_readdatavalid = 1'b1; master_readdata = 32'h55;
    #1;
    chk("lk_rdv", req_readdatavalid, 3'b001);
    chk("lk_rdata", req_readdata, 32'h55);
    tick(); master_readdatavalid = 1'b0;

    // Read routing: requester 0 then requester 2.
    set_req(0, 1'b1, 1'b0, 26'h10, 32'h0);
    #1;
    chk("rr0_addr", master_address, 26'h10);
    chk("rr0_wreq", req_waitrequest, 3'b110);
    tick(); clr();
    set_req(2, 1'b1, 1'b0, 26'h20, 32'h0);
    #1;
    chk("rr2_addr", master_address, 26'h20);
    chk("rr2_wreq", req_waitrequest, 3'b011);
    tick(); clr();
    master_readdatavalid = 1'b1; master_readdata = 32'h11;
    #1;
    chk("ret0_rdv", req_readdatavalid, 3'b001);
    chk("ret0_data", req_readdata, 32'h11);
    tick();
    master_readdata = 32'h22;
    #1;
    chk("ret2_rdv", req_readdatavalid, 3'b100);
    chk("ret2_data", req_readdata, 32'h22);
    tick(); master_readdatavalid = 1'b0;

    // Tag full: four reads from requester 1 fill the FIFO.
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 1'b0, 26'h30 + 26'(k), 32'h0);
      #1;
      chk($sformatf("fill%0d_wreq", k), req_waitrequest, 3'b101);
      tick();
    end
    clr();
    set_req(2, 1'b1, 1'b0, 26'h50, 32'h0);
    master_readdatavalid = 1'b1; master_readdata = 32'h77;
    #1;
    chk("full_wreq", req_waitrequest, 3'b111);
    chk("full_mread", master_read, 0);
    chk("full_pop_rdv", req_readdatavalid, 3'b010);
    tick();
    master_readdatavalid = 1'b0;
    #1;
    chk("full_next_rd", master_read, 1);
    chk("full_next_addr", master_address, 26'h50);
    chk("full_next_wreq", req_waitrequest, 3'b011);
    tick(); clr();
    master_readdatavalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d_rdv", k), req_readdatavalid, (k == 3) ? 3'b100 : 3'b010);
      tick();
    end
    master_readdatavalid = 1'b0;

    // Arbitration with all three requesters writing continuously.
`ifdef ZARB_FIXED_PRIORITY_EN
    exp_wr = '{3'b110, 3'b110, 3'b110, 3'b110};
    exp_ad = '{26'h1000, 26'h1000, 26'h1000, 26'h1000};
`else
    exp_wr = '{3'b110, 3'b101, 3'b011, 3'b110};
    exp_ad = '{26'h1000, 26'h1001, 26'h1002, 26'h1000};
`endif
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b1, 26'h1000 + 26'(i), 32'(i));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb%0d_wreq", k), req_waitrequest, exp_wr[k]);
      chk($sformatf("arb%0d_addr", k), master_address, exp_ad[k]);
      tick();
    end
    clr();

    // Orphan read data with an empty FIFO.
    master_readdatavalid = 1'b1; master_readdata = 32'hDEAD;
    #1;
    chk("orph_rdv", req_readdatavalid, 3'b000);
    chk("orph_err_pre", err_orphan_read, 0);
    tick();
    master_readdatavalid = 1'b0;
    #1;
    chk("orph_err", err_orphan_read, 1);
    tick(); tick(); #1;
    chk("orph_err_hold", err_orphan_read, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("orph_err_clr", err_orphan_read, 0);

    // A read accepted just before reset leaves its return data orphaned.
    set_req(0, 1'b1, 1'b0, 26'h60, 32'h0);
    #1;
    chk("mid_wreq", req_waitrequest, 3'b110);
    tick(); clr();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 26'h64, 32'h0);
    #1;
    chk("mid_rst_mread", master_read, 0);
    tick();
    reset = 1'b0; clr();
    master_readdatavalid = 1'b1; master_readdata = 32'hBEEF;
    #1;
    chk("mid_rdv", req_readdatavalid, 3'b000);
    tick();
    master_readdatavalid = 1'b0;
    #1;
    chk("mid_err", err_orphan_read, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zbuf_mem_arbiter.md
# zbuf_mem_arbiter

Shares the single Avalon-MM SDRAM master between the pixel-pipeline requesters: z-test depth reads, depth write-back, and color write-out. Requesters see an Avalon-style slave port each; the block arbitrates, holds commands stable under `master_waitrequest`, and returns pipelined read data to the requester that issued each read. It sits between the rasterizer/ztest stages and the memory interconnect.

## Interface
- `NREQ`, 3: number of requester ports. Index 0 is highest fixed priority.
- `AW`, 26: address width.
- `DW`, 32: data width.
- `MAX_PEND`, 4: maximum outstanding reads; power of two, 2 to 16.
- `clock` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `req_address` in NREQ*AW: per-requester address; requester i occupies slice [i*AW +: AW].
- `req_read` in NREQ: per-requester read request.
- `req_write` in NREQ: per-requester write request.
- `req_writedata` in NREQ*DW: per-requester write data.
- `req_byteenable` in NREQ*4: per-requester byte enables.
- `req_waitrequest` out NREQ: high means the command is not accepted this cycle.
- `req_readdata` out DW: read data, broadcast to all requesters.
- `req_readdatavalid` out NREQ: one-hot; marks which requester owns `req_readdata`.
- `master_address` out AW: address to memory.
- `master_read` out 1: read command to memory.
- `master_write` out 1: write command to memory.
- `master_byteenable` out 4: byte enables to memory.
- `master_writedata` out DW: write data to memory.
- `master_waitrequest` in 1: memory stall.
- `master_readdata` in DW: read data from memory.
- `master_readdatavalid` in 1: read data valid from memory.
- `err_orphan_read` out 1: sticky; set when read data arrives with no read pending.

## Operation
- Requester i is active when `req_read[i]` or `req_write[i]` is high. If both are high, the command is a write and the read is ignored.
- A read from requester i is eligible only while the tag FIFO is not full. A write is always eligible.
- Grant:
  - When unlocked, one eligible requester is chosen combinationally. The policy is set in Configuration.
  - The master outputs are a combinational mux of the granted requester's command.
  - `master_read` and `master_write` are 0 when there is no grant.
- Lock:
  - If a grant is issued and `master_waitrequest` is high, register `lock` and `lock_idx`.
  - While locked, the grant stays on `lock_idx` regardless of other requests.
  - The lock releases in the cycle the command is accepted (`master_waitrequest` low).
  - Requesters must hold their command until accepted; dropping it mid-lock is a requester protocol violation.
- `req_waitrequest[i]` is low only when i is granted, i is active, and `master_waitrequest` is low. It is high otherwise, including for idle requesters.
- Accepted reads push index i into the tag FIFO (depth MAX_PEND, `$clog2(NREQ)` bits wide). The FIFO has wrapping read/write pointers and a count of `$clog2(MAX_PEND)+1` bits.
- `master_readdatavalid` pops the FIFO head. `req_readdatavalid[head]` = 1 in the same cycle, and `req_readdata` = `master_readdata`, passed through combinationally.
- Push and pop in the same cycle leave the count unchanged. When the FIFO is full, a read is ineligible even if a pop occurs that cycle.
- Readdatavalid with an empty FIFO:
  - the data is dropped;
  - all `req_readdatavalid` bits stay 0;
  - `err_orphan_read` is set to 1 and held until reset.

## Timing
- Arbitration latency is 0 cycles: a request presented while unlocked, with `master_waitrequest` low, is accepted in the same cycle.
- Read-data routing is 0 cycles, master to requester.
- Reset, synchronous: `lock`=0, tag FIFO empty (pointers and count 0), round-robin pointer=0, `err_orphan_read`=0.
- While `reset` is high:
  - `master_read`=`master_write`=0;
  - `req_waitrequest`=all ones;
  - `req_readdatavalid`=0.
- Reset mid-operation drops all pending tags. Read data returning afterwards sets `err_orphan_read`.
- The round-robin pointer updates only on acceptance, to (granted index + 1) mod NREQ. It does not move while locked or idle.

## Configuration
- `ZARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority; the lowest eligible index wins. Requester 0 is depth read and must win over the write-back ports.
  - Undefined (default): round-robin; search starts at the pointer and wraps upward, and the first eligible index wins.
- Lock, tag FIFO, and error behaviour are identical in both builds.

## Test plan
- Single write: req 2 writes addr 0x100, data 0xAABBCC, waitrequest low → `master_write`=1, same values on the master port; `req_waitrequest[2]`=0 that cycle.
- Lock under stall: req 1 writes while `master_waitrequest` is high for 3 cycles and req 0 reads in parallel → master stays on req 1 for 4 cycles; req 0 is accepted in cycle 5.
- Read routing: reads from req 0 (addr 0x10), then req 2 (0x20), both accepted; memory returns 0x11 then 0x22 → `req_readdatavalid` = 001 then 100 with the matching data.
- Tag full: MAX_PEND=4, four reads outstanding, a fifth is requested, plus a concurrent pop → fifth read is stalled that cycle and accepted the next.
- Arbitration:
  - Round-robin build: reqs 0, 1, 2 write continuously → grant order 0, 1, 2, 0.
  - `ZARB_FIXED_PRIORITY_EN` build: same stimulus → always 0.
- Orphan: `master_readdatavalid` pulse with no read pending, and again right after a mid-flight reset → data dropped, `err_orphan_read`=1 until next reset.
